subik_clk_div: RTL and testbench

- Registered clock divider that turns the top-level clock into a slower square wave. The default setting divides by 2.
- It also produces a one-cycle tick in the source clock domain, aligned with each rising edge of the divided output.
- Feeds logic that needs a half-rate (or 1/N-rate) signal derived from the system clock.
- Downstream synchronous logic uses oTick as a clock enable. oClockDiv is for pins and probes only and is not used as a fabric clock.

---
 rtl/subik_clk_div.sv | 54 +++++
 tb/tb_subik_clk_div.sv | 118 +++++++++++
 2 files changed

// File: rtl/subik_clk_div.sv
// rtl/subik_clk_div.sv - registered divide-by-N clock with a source-domain tick on each rising edge
module subik_clk_div #(
  parameter int Divisor = 2
) (
  input  logic iClock,
  input  logic iReset_n,
  input  logic iEnable,
  output logic oClockDiv,
  output logic oTick
);

  localparam int HighTicks  = Divisor / 2;
  localparam int CounterMSB = (Divisor > 2) ? $clog2(Divisor) - 1 : 0;

  localparam logic [CounterMSB:0] LastCount = (CounterMSB + 1)'(Divisor - 1);
  localparam logic [CounterMSB:0] HighCount = (CounterMSB + 1)'(HighTicks);
  localparam logic [CounterMSB:0] CountOne  = (CounterMSB + 1)'(1);

  if (Divisor < 2) begin : g_divisor_check
    $error("subik_clk_div: Divisor must be >= 2");
  end

  logic [CounterMSB:0] counter_q, counter_d;
  logic                clock_div_q, clock_div_d;
  logic                tick_q, tick_d;

  // Outputs are decoded from the counter's next value so they line up with the edge that loads it.
  always_comb begin
    counter_d   = counter_q;
    clock_div_d = clock_div_q;
    tick_d      = 1'b0;
    if (iEnable) begin
      counter_d   = (counter_q == LastCount) ? '0 : counter_q + CountOne;
      clock_div_d = (counter_d < HighCount);
      tick_d      = (counter_d == '0);
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      counter_q   <= '0;
      clock_div_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      clock_div_q <= clock_div_d;
      tick_q      <= tick_d;
    end
  end

  assign oClockDiv = clock_div_q;
  assign oTick     = tick_q;

endmodule

// File: tb/tb_subik_clk_div.sv
// tb/tb_subik_clk_div.sv - directed bench for subik_clk_div at divisors 2, 3, 4 and 5
module tb_subik_clk_div;

  logic clk;
  logic rst_n;
  logic en2, en3, en4, en5;
  logic div2, div3, div4, div5;
  logic tick2, tick3, tick4, tick5;

  int checks_total;
  int checks_passed;

  subik_clk_div #(.Divisor(2)) u_div2 (
    .iClock(clk), .iReset_n(rst_n), .iEnable(en2), .oClockDiv(div2), .oTick(tick2)
  );
  subik_clk_div #(.Divisor(3)) u_div3 (
    .iClock(clk), .iReset_n(rst_n), .iEnable(en3), .oClockDiv(div3), .oTick(tick3)
  );
  subik_clk_div #(.Divisor(4)) u_div4 (
    .iClock(clk), .iReset_n(rst_n), .iEnable(en4), .oClockDiv(div4), .oTick(tick4)
  );
  subik_clk_div #(.Divisor(5)) u_div5 (
    .iClock(clk), .iReset_n(rst_n), .iEnable(en5), .oClockDiv(div5), .oTick(tick5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Divisor=4 with enable dropped after edge 2 for 5 cycles; bit 11 is edge 1.
  logic [11:0] en4_tab;
  logic [11:0] div4_tab;
  logic [11:0] tick4_tab;

  int ticks5;
  int highs5;

  initial begin
    en4_tab   = 12'b1100_0001_1111;
    div4_tab  = 12'b1000_0000_1100;
    tick4_tab = 12'b0000_0000_1000;
    checks_total  = 0;
    checks_passed = 0;
    ticks5 = 0;
    highs5 = 0;

    rst_n = 1'b0;
    en2 = 1'b1; en3 = 1'b1; en4 = 1'b1; en5 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_div2", div2, 0);
    check("reset_tick2", tick2, 0);
    check("reset_div3", div3, 0);
    check("reset_div4", div4, 0);
    check("reset_tick4", tick4, 0);
    check("reset_div5", div5, 0);
    check("reset_tick5", tick5, 0);

    rst_n = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      if (k <= 12) en4 = en4_tab[12 - k];
      else en4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (k <= 4) begin
        check($sformatf("div2_e%0d", k), div2, (k % 2 == 0));
        check($sformatf("tick2_e%0d", k), tick2, (k % 2 == 0));
      end
      if (k <= 6) begin
        check($sformatf("div3_e%0d", k), div3, (k % 3 == 0));
        check($sformatf("tick3_e%0d", k), tick3, (k % 3 == 0));
      end
      if (k <= 12) begin
        check($sformatf("div4_e%0d", k), div4, div4_tab[12 - k]);
        check($sformatf("tick4_e%0d", k), tick4, tick4_tab[12 - k]);
      end
      check($sformatf("div5_e%0d", k), div5, ((k % 5) < 2));
      if (tick5) ticks5++;
      if (div5) highs5++;
    end
    check("tick5_count_50", ticks5, 10);
    check("div5_high_cycles_50", highs5, 20);

    check("div2_high_before_reset", div2, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_div2", div2, 0);
    check("async_reset_tick2", tick2, 0);
    @(posedge clk);
    @(negedge clk);
    check("held_reset_div2", div2, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rerun_div2_e%0d", k), div2, (k % 2 == 0));
      check($sformatf("rerun_tick2_e%0d", k), tick2, (k % 2 == 0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
